// File: rtl/aib_axi_mem_responder.sv
// AXI-MM subordinate that terminates the user port of the AIB-to-AXI follower
// bridge. Write data lands in a word-addressed register array; reads return
// registered data. INCR and FIXED bursts are served. Other burst types are
// answered with SLVERR, and beats outside the array window with DECERR.
module aib_axi_mem_responder #(
    parameter int                    ADDRWIDTH = 32,
    parameter int                    DWIDTH    = 64,
    parameter int                    IDWIDTH   = 4,
    parameter int                    MEM_WORDS = 256,
    parameter logic [ADDRWIDTH-1:0]  BASE_ADDR = '0
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr,
    // write address
    input  logic [IDWIDTH-1:0]     awid,
    input  logic [ADDRWIDTH-1:0]   awaddr,
    input  logic [7:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    // write data
    input  logic [DWIDTH-1:0]      wdata,
    input  logic [DWIDTH/8-1:0]    wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    // write response
    output logic [IDWIDTH-1:0]     bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    // read address
    input  logic [IDWIDTH-1:0]     arid,
    input  logic [ADDRWIDTH-1:0]   araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    // read data
    output logic [IDWIDTH-1:0]     rid,
    output logic [DWIDTH-1:0]      rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int                   NBYTES    = DWIDTH / 8;
    localparam int                   OFFW      = $clog2(NBYTES);
    localparam int                   IDXW      = $clog2(MEM_WORDS);
    localparam logic [2:0]           MAX_SIZE  = 3'(OFFW);
    localparam logic [ADDRWIDTH:0]   MEM_BYTES = (ADDRWIDTH+1)'(MEM_WORDS * NBYTES);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    // Offset is taken one bit wider than the address so that an address below
    // BASE_ADDR borrows into the top bit and always compares as out of range.
    function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
        logic [ADDRWIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return off < MEM_BYTES;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDRWIDTH-1:0] a);
        logic [ADDRWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[OFFW +: IDXW];
    endfunction

    // Sizes wider than the bus are clamped to full width.
    function automatic logic [ADDRWIDTH-1:0] next_addr(input logic [ADDRWIDTH-1:0] a,
                                                       input logic [2:0]           size,
                                                       input logic [1:0]           burst);
        logic [2:0] s;
        s = (size > MAX_SIZE) ? MAX_SIZE : size;
        if (burst == BURST_INCR)
            return a + (ADDRWIDTH'(1) << s);
        return a;
    endfunction

    logic [DWIDTH-1:0]    r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    logic [1:0]           r_wstate;
    logic [IDWIDTH-1:0]   r_awid;
    logic [ADDRWIDTH-1:0] r_waddr;
    logic [7:0]           r_awlen;
    logic [7:0]           r_wcnt;
    logic [2:0]           r_awsize;
    logic [1:0]           r_awburst;
    logic                 r_wdec;
    logic                 r_wslv;
    logic [IDWIDTH-1:0]   r_bid;
    logic [1:0]           r_bresp;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_wcnt_last;
    logic                 w_wend;
    logic                 w_winr;
    logic                 w_wunsup;
    logic                 w_wdec_any;
    logic                 w_wslv_any;
    logic                 w_mem_we;
    logic [IDXW-1:0]      w_widx;

    assign awready     = (r_wstate == W_IDLE);
    assign wready      = (r_wstate == W_DATA);
    assign bvalid      = (r_wstate == W_RESP);
    assign bid         = r_bid;
    assign bresp       = r_bresp;

    assign w_aw_hs     = awvalid && awready;
    assign w_w_hs      = wvalid && wready;
    assign w_wcnt_last = (r_wcnt == r_awlen);
    // The burst closes on whichever comes first: wlast or the awlen+1 beat.
    assign w_wend      = wlast || w_wcnt_last;
    assign w_winr      = in_range(r_waddr);
    assign w_wunsup    = r_awburst[1];
    assign w_widx      = word_idx(r_waddr);
    // Error flags including the beat currently on the bus. A wlast that
    // disagrees with the beat count, in either direction, is a protocol error.
    assign w_wdec_any  = r_wdec || !w_winr;
    assign w_wslv_any  = r_wslv || w_wunsup || (wlast != w_wcnt_last);
    assign w_mem_we    = w_w_hs && w_winr && !w_wunsup && !rst_wr;

    // Write FSM, beat counter, sticky error flags and registered B response
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_wdec   <= 1'b0;
            r_wslv   <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate <= W_DATA;
                        r_wcnt   <= '0;
                        r_wdec   <= 1'b0;
                        r_wslv   <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wdec <= w_wdec_any;
                        r_wslv <= w_wslv_any;
                        r_wcnt <= r_wcnt + 8'd1;
                        if (w_wend) begin
                            r_wstate <= W_RESP;
                            r_bid    <= r_awid;
                            r_bresp  <= w_wdec_any ? RESP_DECERR :
                                        w_wslv_any ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (bready)
                        r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Captured AW fields and running beat address
    always_ff @(posedge clk_wr) begin
        if (w_aw_hs) begin
            r_awid    <= awid;
            r_waddr   <= awaddr;
            r_awlen   <= awlen;
            r_awsize  <= awsize;
            r_awburst <= awburst;
        end else if (w_w_hs) begin
            r_waddr   <= next_addr(r_waddr, r_awsize, r_awburst);
        end
    end

    // Byte-lane writes into the array; contents survive reset
    always_ff @(posedge clk_wr) begin
        if (w_mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb[b])
                    r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    logic                 r_rstate;
    logic [IDWIDTH-1:0]   r_rid;
    logic [ADDRWIDTH-1:0] r_raddr;
    logic [7:0]           r_arlen;
    logic [7:0]           r_rcnt;
    logic [2:0]           r_arsize;
    logic [1:0]           r_arburst;
    logic [DWIDTH-1:0]    r_rdata;
    logic [1:0]           r_rresp;
    logic                 r_rlast;

    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_rload;
    logic [ADDRWIDTH-1:0] w_rsrc_addr;
    logic [1:0]           w_rsrc_burst;
    logic                 w_rsrc_inr;
    logic                 w_rsrc_last;
    logic [7:0]           w_rcnt_nxt;
    logic [IDXW-1:0]      w_ridx;

    assign arready      = (r_rstate == R_IDLE);
    assign rvalid       = (r_rstate == R_DATA);
    assign rid          = r_rid;
    assign rdata        = r_rdata;
    assign rresp        = r_rresp;
    assign rlast        = r_rlast;

    assign w_ar_hs      = arvalid && arready;
    assign w_r_hs       = rready && rvalid;
    // A new beat is fetched on AR acceptance and on every accepted non-final
    // beat; otherwise the output registers hold, which keeps R stable under
    // back-pressure.
    assign w_rload      = w_ar_hs || (w_r_hs && !r_rlast);
    assign w_rcnt_nxt   = r_rcnt + 8'd1;
    assign w_rsrc_addr  = w_ar_hs ? araddr  : r_raddr;
    assign w_rsrc_burst = w_ar_hs ? arburst : r_arburst;
    assign w_rsrc_last  = w_ar_hs ? (arlen == 8'd0) : (w_rcnt_nxt == r_arlen);
    assign w_rsrc_inr   = in_range(w_rsrc_addr);
    assign w_ridx       = word_idx(w_rsrc_addr);

    // Read FSM and registered R beat; reading the array here returns the
    // pre-write value when a write to the same word lands on the same edge
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rid    <= arid;
            end else if (w_r_hs && r_rlast) begin
                r_rstate <= R_IDLE;
                r_rlast  <= 1'b0;
            end
            if (w_rload) begin
                r_rlast <= w_rsrc_last;
                if (!w_rsrc_inr) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_DECERR;
                end else if (w_rsrc_burst[1]) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end else begin
                    r_rdata <= r_mem[w_ridx];
                    r_rresp <= RESP_OKAY;
                end
            end
        end
    end

    // Captured AR fields; r_raddr always points at the beat after the one shown
    always_ff @(posedge clk_wr) begin
        if (w_ar_hs) begin
            r_raddr   <= next_addr(araddr, arsize, arburst);
            r_arlen   <= arlen;
            r_arsize  <= arsize;
            r_arburst <= arburst;
            r_rcnt    <= '0;
        end else if (w_r_hs && !r_rlast) begin
            r_raddr   <= next_addr(r_raddr, r_arsize, r_arburst);
            r_rcnt    <= w_rcnt_nxt;
        end
    end

endmodule

// File: tb/tb_aib_axi_mem_responder.sv
// Randomized self-checking bench for aib_axi_mem_responder with a
// burst-level reference model of the memory and its responses.
module tb_aib_axi_mem_responder;

    localparam logic [31:0] MEM_BYTES = 32'd2048;

    logic        clk_wr = 1'b0;
    logic        rst_wr = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rvalid, rready = 1'b0, rlast;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;

    int checks = 0;
    int errors = 0;

    logic [63:0] mm [256];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] ex_data [256];
    logic [1:0]  ex_resp [256];
    logic [63:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id   [256];
    int          rd_cnt;
    int          hold_viol;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    int          b_hold_viol;

    always #5 clk_wr = ~clk_wr;

    aib_axi_mem_responder dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // ---------------- reference model ----------------
    task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int wlast_at, output logic [1:0] exp);
        logic [31:0] a;
        logic [2:0]  es;
        bit          dec, slv;
        int          nb;
        es  = (size > 3'd3) ? 3'd3 : size;
        a   = addr;
        dec = 0;
        slv = burst[1] || (wlast_at != int'(len));
        nb  = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
        for (int i = 0; i < nb; i++) begin
            if (a >= MEM_BYTES) dec = 1;
            else if (!burst[1]) begin
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) mm[a[10:3]][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            if (burst == 2'b01) a = a + (32'd1 << es);
        end
        exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [2:0]  es;
        es = (size > 3'd3) ? 3'd3 : size;
        a  = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (a >= MEM_BYTES) begin ex_resp[i] = 2'b11; ex_data[i] = '0; end
            else if (burst[1]) begin ex_resp[i] = 2'b10; ex_data[i] = '0; end
            else begin ex_resp[i] = 2'b00; ex_data[i] = mm[a[10:3]]; end
            if (burst == 2'b01) a = a + (32'd1 << es);
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_at, input int bstall);
        int t;
        int nb;
        nb = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
        @(negedge clk_wr);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk_wr); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL aw_timeout awready=%b", awready); end
        @(negedge clk_wr);
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 200) begin @(negedge clk_wr); t++; end
            if (t >= 200) begin checks++; errors++; $display("FAIL w_timeout beat %0d", i); end
            @(negedge clk_wr);
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 200) begin @(negedge clk_wr); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b", bvalid); end
        b_id = bid; b_resp = bresp; b_hold_viol = 0;
        for (int k = 0; k < bstall; k++) begin
            @(negedge clk_wr);
            if (!bvalid || bid !== b_id || bresp !== b_resp) b_hold_viol++;
        end
        bready = 1'b1;
        @(negedge clk_wr);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int t, cyc;
        bit snap;
        logic [63:0] sd; logic [1:0] sr; logic sl; logic [3:0] si;
        @(negedge clk_wr);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk_wr); t++; end
        if (t >= 200) begin checks++; errors++; $display("FAIL ar_timeout arready=%b", arready); end
        @(negedge clk_wr);
        arvalid = 1'b0;
        rd_cnt = 0; hold_viol = 0; snap = 0; cyc = 0;
        sd = '0; sr = '0; sl = 1'b0; si = '0;
        while (rd_cnt < int'(len) + 1 && cyc < 2000) begin
            rready = stall ? (cyc % 2 == 1) : 1'b1;
            if (snap) begin
                if (!rvalid || rdata !== sd || rresp !== sr || rlast !== sl || rid !== si) hold_viol++;
                snap = 0;
            end
            if (rvalid) begin
                if (rready) begin
                    rd_data[rd_cnt] = rdata; rd_resp[rd_cnt] = rresp;
                    rd_last[rd_cnt] = rlast; rd_id[rd_cnt] = rid;
                    rd_cnt++;
                end else begin
                    sd = rdata; sr = rresp; sl = rlast; si = rid; snap = 1;
                end
            end
            if (rd_cnt < int'(len) + 1) begin @(negedge clk_wr); cyc++; end
        end
        if (cyc >= 2000) begin checks++; errors++; $display("FAIL r_timeout beats got %0d need %0d", rd_cnt, int'(len) + 1); end
        @(negedge clk_wr);
        rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_wr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_wr);
            awvalid = 1'($urandom); wvalid = 1'($urandom); arvalid = 1'($urandom);
            bready = 1'($urandom); rready = 1'($urandom);
        end
        @(negedge clk_wr);
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got %b exp 1", awready); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got %b exp 1", arready); end
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b exp 0", wready); end
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", bvalid); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got %b exp 0", rlast); end
        checks++; if (bresp !== 2'b00 || rresp !== 2'b00) begin errors++; $display("FAIL reset_resp got b=%b r=%b exp 0", bresp, rresp); end
        checks++; if (bid !== 4'd0 || rid !== 4'd0) begin errors++; $display("FAIL reset_ids got b=%0d r=%0d exp 0", bid, rid); end
        checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        rst_wr = 1'b0;
        @(negedge clk_wr);
        checks++; if (awready !== 1'b1 || arready !== 1'b1) begin errors++; $display("FAIL release_ready got aw=%b ar=%b exp 1", awready, arready); end
    endtask

    task automatic test_incr();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
        model_write(32'h10, 8'd3, 3'd3, 2'b01, 3, exp);
        do_write(4'd5, 32'h10, 8'd3, 3'd3, 2'b01, 3, 2);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL incr_bresp got %b exp %b", b_resp, exp); end
        checks++; if (b_id !== 4'd5) begin errors++; $display("FAIL incr_bid got %0d exp 5", b_id); end
        checks++; if (b_hold_viol !== 0) begin errors++; $display("FAIL incr_bhold got %0d exp 0", b_hold_viol); end
        model_read(32'h10, 8'd3, 3'd3, 2'b01);
        do_read(4'd5, 32'h10, 8'd3, 3'd3, 2'b01, 0);
        checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL incr_beats got %0d exp 4", rd_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data[i] !== ex_data[i]) begin errors++; $display("FAIL incr_rdata[%0d] got %h exp %h", i, rd_data[i], ex_data[i]); end
            checks++; if (rd_last[i] !== (i == 3)) begin errors++; $display("FAIL incr_rlast[%0d] got %b exp %b", i, rd_last[i], i == 3); end
            checks++; if (rd_id[i] !== 4'd5 || rd_resp[i] !== 2'b00) begin errors++; $display("FAIL incr_rid_rresp[%0d] got id=%0d resp=%b exp 5/00", i, rd_id[i], rd_resp[i]); end
        end
    endtask

    task automatic test_strobe_stall();
        logic [1:0] exp;
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        model_write(32'h80, 8'd0, 3'd3, 2'b01, 0, exp);
        do_write(4'd1, 32'h80, 8'd0, 3'd3, 2'b01, 0, 0);
        wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'h0F;
        model_write(32'h80, 8'd0, 3'd3, 2'b01, 0, exp);
        do_write(4'd2, 32'h80, 8'd0, 3'd3, 2'b01, 0, 0);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL strobe_bresp got %b exp %b", b_resp, exp); end
        do_read(4'd3, 32'h80, 8'd0, 3'd3, 2'b01, 1);
        checks++; if (rd_data[0] !== 64'hFFFF_FFFF_5566_7788) begin errors++; $display("FAIL strobe_rdata got %h exp ffffffff55667788", rd_data[0]); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", hold_viol); end
        checks++; if (rd_last[0] !== 1'b1) begin errors++; $display("FAIL single_rlast got %b exp 1", rd_last[0]); end
    endtask

    task automatic test_fill();
        logic [1:0] exp;
        int bad;
        for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        model_write(32'h0, 8'd255, 3'd3, 2'b01, 255, exp);
        do_write(4'd7, 32'h0, 8'd255, 3'd3, 2'b01, 255, 0);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL fill_bresp got %b exp %b", b_resp, exp); end
        model_read(32'h0, 8'd255, 3'd7, 2'b01);
        do_read(4'd7, 32'h0, 8'd255, 3'd7, 2'b01, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (rd_data[i] !== ex_data[i] || rd_last[i] !== (i == 255)) bad++;
        checks++; if (bad !== 0 || rd_cnt !== 256) begin errors++; $display("FAIL fill_readback got %0d bad beats of %0d exp 0 of 256", bad, rd_cnt); end
    endtask

    task automatic test_errors();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        model_write(MEM_BYTES, 8'd1, 3'd3, 2'b01, 1, exp);
        do_write(4'd3, MEM_BYTES, 8'd1, 3'd3, 2'b01, 1, 0);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL oor_bresp got %b exp %b", b_resp, exp); end
        model_read(32'h0, 8'd1, 3'd3, 2'b01);
        do_read(4'd3, 32'h0, 8'd1, 3'd3, 2'b01, 0);
        checks++; if (rd_data[0] !== ex_data[0] || rd_data[1] !== ex_data[1]) begin errors++; $display("FAIL oor_unchanged got %h %h exp %h %h", rd_data[0], rd_data[1], ex_data[0], ex_data[1]); end

        model_write(32'h100, 8'd1, 3'd3, 2'b10, 1, exp);
        do_write(4'd4, 32'h100, 8'd1, 3'd3, 2'b10, 1, 0);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL wrap_bresp got %b exp %b", b_resp, exp); end
        model_read(32'h100, 8'd1, 3'd3, 2'b01);
        do_read(4'd4, 32'h100, 8'd1, 3'd3, 2'b01, 0);
        checks++; if (rd_data[0] !== ex_data[0] || rd_data[1] !== ex_data[1]) begin errors++; $display("FAIL wrap_unchanged got %h %h exp %h %h", rd_data[0], rd_data[1], ex_data[0], ex_data[1]); end

        model_write(32'h200, 8'd2, 3'd3, 2'b01, 0, exp);
        do_write(4'd6, 32'h200, 8'd2, 3'd3, 2'b01, 0, 0);
        checks++; if (b_resp !== exp) begin errors++; $display("FAIL early_wlast_bresp got %b exp %b", b_resp, exp); end
        checks++; if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL early_wlast_idle got aw=%b w=%b b=%b exp 1 0 0", awready, wready, bvalid); end

        model_read(32'h900, 8'd1, 3'd3, 2'b01);
        do_read(4'd9, 32'h900, 8'd1, 3'd3, 2'b01, 0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (rd_resp[i] !== ex_resp[i] || rd_data[i] !== ex_data[i]) begin errors++; $display("FAIL ar_oor[%0d] got %b/%h exp %b/%h", i, rd_resp[i], rd_data[i], ex_resp[i], ex_data[i]); end
        end
        model_read(32'h0, 8'd0, 3'd3, 2'b11);
        do_read(4'd2, 32'h0, 8'd0, 3'd3, 2'b11, 0);
        checks++; if (rd_resp[0] !== ex_resp[0] || rd_data[0] !== ex_data[0]) begin errors++; $display("FAIL ar_unsup got %b/%h exp %b/%h", rd_resp[0], rd_data[0], ex_resp[0], ex_data[0]); end
    endtask

    task automatic test_concurrency();
        logic [1:0] exp;
        logic [63:0] old_val;
        model_read(32'h40, 8'd0, 3'd3, 2'b01);
        old_val = ex_data[0];
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        model_write(32'h40, 8'd3, 3'd3, 2'b00, 3, exp);
        fork
            do_write(4'd8, 32'h40, 8'd3, 3'd3, 2'b00, 3, 0);
            begin
                @(negedge clk_wr);
                do_read(4'd9, 32'h40, 8'd0, 3'd3, 2'b01, 0);
            end
        join
        checks++; if (rd_data[0] !== old_val) begin errors++; $display("FAIL conc_read_old got %h exp %h", rd_data[0], old_val); end
        checks++; if (rd_resp[0] !== 2'b00 || b_resp !== exp) begin errors++; $display("FAIL conc_resp got r=%b b=%b exp 00 %b", rd_resp[0], b_resp, exp); end
        model_read(32'h40, 8'd0, 3'd3, 2'b01);
        do_read(4'd9, 32'h40, 8'd0, 3'd3, 2'b01, 0);
        checks++; if (rd_data[0] !== ex_data[0]) begin errors++; $display("FAIL conc_fixed_final got %h exp %h", rd_data[0], ex_data[0]); end
    endtask

    task automatic test_random();
        logic [1:0]  exp;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wl;
        for (int n = 0; n < 30; n++) begin
            id    = 4'($urandom);
            addr  = 32'($urandom_range(0, 262)) << 3;
            len   = 8'($urandom_range(0, 7));
            size  = 3'($urandom_range(0, 7));
            burst = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            wl    = ($urandom_range(0, 6) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
            for (int i = 0; i < 9; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            model_write(addr, len, size, burst, wl, exp);
            do_write(id, addr, len, size, burst, wl, $urandom_range(0, 2));
            checks++; if (b_resp !== exp || b_id !== id) begin errors++; $display("FAIL rand_b[%0d] got %0d/%b exp %0d/%b", n, b_id, b_resp, id, exp); end
            checks++; if (b_hold_viol !== 0) begin errors++; $display("FAIL rand_bhold[%0d] got %0d exp 0", n, b_hold_viol); end
            model_read(addr, len, size, burst);
            do_read(id, addr, len, size, burst, 1'($urandom));
            checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_rhold[%0d] got %0d exp 0", n, hold_viol); end
            for (int i = 0; i <= int'(len); i++) begin
                checks++;
                if (rd_data[i] !== ex_data[i] || rd_resp[i] !== ex_resp[i] || rd_last[i] !== (i == int'(len)) || rd_id[i] !== id) begin
                    errors++;
                    $display("FAIL rand_r[%0d][%0d] got %h/%b/%b/%0d exp %h/%b/%b/%0d", n, i,
                             rd_data[i], rd_resp[i], rd_last[i], rd_id[i], ex_data[i], ex_resp[i], i == int'(len), id);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [63:0] v;
        v = {$urandom, $urandom};
        @(negedge clk_wr);
        awid = 4'd1; awaddr = 32'h20; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd2; araddr = 32'h0; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        rready = 1'b0;
        @(negedge clk_wr);
        awvalid = 1'b0; arvalid = 1'b0;
        wdata = v; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        checks++; if (rvalid !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL mid_active got rvalid=%b wready=%b exp 1 1", rvalid, wready); end
        @(negedge clk_wr);
        wvalid = 1'b0; rst_wr = 1'b1;
        mm[4] = v;
        @(negedge clk_wr);
        rst_wr = 1'b0;
        checks++; if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL mid_wabort got aw=%b w=%b b=%b exp 1 0 0", awready, wready, bvalid); end
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0 || rdata !== 64'd0 || rlast !== 1'b0) begin errors++; $display("FAIL mid_rabort got ar=%b rv=%b rd=%h rl=%b exp 1 0 0 0", arready, rvalid, rdata, rlast); end
        model_read(32'h20, 8'd0, 3'd3, 2'b01);
        do_read(4'd3, 32'h20, 8'd0, 3'd3, 2'b01, 0);
        checks++; if (rd_data[0] !== ex_data[0]) begin errors++; $display("FAIL mid_partial_kept got %h exp %h", rd_data[0], ex_data[0]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_incr();
        test_strobe_stall();
        test_fill();
        test_errors();
        test_concurrency();
        test_random();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aib_axi_mem_responder.md
# aib_axi_mem_responder

AXI-MM responder (subordinate) that terminates the user AXI port driven by the AIB-to-AXI follower bridge. It accepts AW/W/AR requests from that bridge, stores write data in an internal word-addressed register array, and returns B and R responses with ID echo, INCR/FIXED burst support and error responses. It serves as the far-end target for loopback and bring-up of the single-channel AIB Gen2 link.

## Interface
- ADDRWIDTH, 32: AXI address width.
- DWIDTH, 64: data width; WSTRB is DWIDTH/8 bits.
- IDWIDTH, 4: AWID/ARID/BID/RID width.
- MEM_WORDS, 256: array depth in DWIDTH words; power of 2.
- BASE_ADDR, 0: byte address of word 0.
- clk_wr  in  1  block clock; all logic on its rising edge.
- rst_wr  in  1  synchronous, active-high reset.
- awid/awaddr/awlen/awsize/awburst  in  IDWIDTH/ADDRWIDTH/8/3/2  write address.
- awvalid in 1, awready out 1: AW handshake.
- wdata/wstrb/wlast  in  DWIDTH/DWIDTH/8/1  write data.
- wvalid in 1, wready out 1: W handshake.
- bid/bresp  out  IDWIDTH/2  write response.
- bvalid out 1, bready in 1: B handshake.
- arid/araddr/arlen/arsize/arburst  in  as AW fields.
- arvalid in 1, arready out 1: AR handshake.
- rid/rdata/rresp/rlast  out  IDWIDTH/DWIDTH/2/1  read data.
- rvalid out 1, rready in 1: R handshake.

## Operation
- Write FSM: W_IDLE -> W_DATA on AW handshake. W_DATA -> W_RESP on the W handshake that ends the burst. W_RESP -> W_IDLE on B handshake.
- awready=1 only in W_IDLE. wready=1 only in W_DATA. bvalid=1 only in W_RESP.
- Read FSM: R_IDLE -> R_DATA on AR handshake. R_DATA -> R_IDLE on the R handshake with rlast=1.
- arready=1 only in R_IDLE. rvalid=1 only in R_DATA.
- Read and write FSMs are fully independent; no cross-channel ordering.
- Word index = (addr - BASE_ADDR) >> log2(DWIDTH/8).
- A beat is in range when BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*DWIDTH/8.
- Next address:
  - INCR (2'b01): addr + (1 << size), ADDRWIDTH-bit wrap.
  - FIXED (2'b00): addr unchanged.
- Write beat: byte lanes with wstrb=1 are updated. Nothing is written if the beat is out of range or the burst type is unsupported.
- Write burst ends on wlast=1 or on beat awlen+1, whichever comes first. A wlast position mismatch sets a sticky SLVERR for the burst.
- Burst types 2'b10 and 2'b11 are unsupported: beats are consumed normally, response is SLVERR (2'b10), no array access.
- bresp priority: DECERR (2'b11) if any beat was out of range, else SLVERR, else OKAY (2'b00).
- rresp is evaluated per beat: DECERR if out of range (rdata=0), SLVERR for unsupported burst (rdata=0), else OKAY.
- rlast=1 on beat arlen+1. bid/rid echo the captured awid/arid.
- awsize/arsize larger than log2(DWIDTH/8) is treated as full width.

## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. Array contents are not reset.
- Reset mid-burst aborts both FSMs at the next edge. Partially written words keep the data already written.
- AW accepted at cycle N: wready=1 from cycle N+1.
- Last W accepted at cycle M: bvalid=1 at cycle M+1.
- AR accepted at cycle N: first rvalid at cycle N+1, with registered rdata.
- Under rready=1, one beat per cycle, no bubbles.
- While rvalid=1 and rready=0: rdata/rresp/rlast/rid hold stable.
- While bvalid=1 and bready=0: bid/bresp hold stable.
- A read and a write to the same word in the same cycle: the read returns the pre-write data.
- arlen=0 / awlen=0 is a single beat; rlast=1 on the first beat.

## Test plan
- Reset: assert rst_wr for 2 cycles with valid inputs toggling -> all outputs at their reset values; awready=arready=1 the cycle after release.
- INCR write then read: AW addr 0x10, len 3, size 3, id 5, data 0xA0..0xA3, full strobe -> bresp=0, bid=5. AR of the same burst -> rdata 0xA0..0xA3, rlast only on the 4th beat, rid=5.
- Strobe and back-pressure: write 0xFFFF_FFFF_FFFF_FFFF, then 0x1122334455667788 with wstrb=0x0F. Read with rready toggled 1/0 -> rdata=0xFFFF_FFFF_55667788, held stable while stalled.
- Errors:
  - AW at BASE_ADDR + MEM_WORDS*8, len 1 -> bresp=2'b11, array unchanged.
  - awburst=2'b10 -> bresp=2'b10.
  - wlast on beat 1 of a len=2 burst -> bresp=2'b10, FSM back in W_IDLE after B.
  - AR out of range -> rresp=2'b11, rdata=0.
- Concurrency: FIXED write of 4 beats to 0x40 concurrent with an INCR read of 0x40 len 0 -> read returns the old value, write leaves the last beat's data in the word, both responses are OKAY.
